// File: rtl/wb_pipe_pkg.sv
// Shared types and defaults for the write-back control pipeline.
`timescale 1ns/1ps
package wb_pipe_pkg;

  localparam int WB_W_DEF = 2;
  localparam int RD_W_DEF = 5;

  // Write-back mux select encodings.
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef struct packed {
    logic                valid;
    logic                wer;
    logic [WB_W_DEF-1:0] wb_sel;
    logic [RD_W_DEF-1:0] rd;
  } wb_stage_t;

endpackage

// File: rtl/wb_pipe_stage.sv
// One register stage of the write-back control pipeline with hold and clear.
`timescale 1ns/1ps
module wb_pipe_stage
  import wb_pipe_pkg::*;
#(
  parameter int WB_W = WB_W_DEF,
  parameter int RD_W = RD_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            clear,
  input  logic            d_valid,
  input  logic            d_wer,
  input  logic [WB_W-1:0] d_wb_sel,
  input  logic [RD_W-1:0] d_rd,
  output logic            q_valid,
  output logic            q_wer,
  output logic [WB_W-1:0] q_wb_sel,
  output logic [RD_W-1:0] q_rd
);

  // Invalid entries are captured as all-zero so downstream never sees stale fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_valid  <= 1'b0;
      q_wer    <= 1'b0;
      q_wb_sel <= '0;
      q_rd     <= '0;
    end else if (clear) begin
      q_valid  <= 1'b0;
      q_wer    <= 1'b0;
      q_wb_sel <= '0;
      q_rd     <= '0;
    end else if (!hold) begin
      q_valid  <= d_valid;
      q_wer    <= d_valid & d_wer;
      q_wb_sel <= d_valid ? d_wb_sel : '0;
      q_rd     <= d_valid ? d_rd : '0;
    end
  end

endmodule

// File: rtl/wb_ctrl_pipe.sv
// Write-back control delay line with valid tracking, stall, flush and RAW hazard flags.
`timescale 1ns/1ps
module wb_ctrl_pipe
  import wb_pipe_pkg::*;
#(
  parameter int STAGES    = 3,
  parameter int WB_W      = WB_W_DEF,
  parameter int RD_W      = RD_W_DEF,
  parameter int WB_BYPASS = 1,
  localparam int OCC_W    = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_wer,
  input  logic [WB_W-1:0]  in_wb_sel,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             stall,
  input  logic             flush,
  input  logic [RD_W-1:0]  rs1,
  input  logic [RD_W-1:0]  rs2,
  output logic             werf_contrl,
  output logic [WB_W-1:0]  wb_contrl,
  output logic [RD_W-1:0]  wb_rd,
  output logic             out_valid,
  output logic             hazard_rs1,
  output logic             hazard_rs2,
  output logic [OCC_W-1:0] occupancy
);

  // With a write-first register file the last stage forwards itself, so it is not compared.
  localparam int HC = (WB_BYPASS != 0) ? STAGES - 1 : STAGES;

  logic            st_valid  [STAGES];
  logic            st_wer    [STAGES];
  logic [WB_W-1:0] st_wb_sel [STAGES];
  logic [RD_W-1:0] st_rd     [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic            d_valid;
    logic            d_wer;
    logic [WB_W-1:0] d_wb_sel;
    logic [RD_W-1:0] d_rd;

    if (k == 0) begin : g_head
      assign d_valid  = in_valid;
      assign d_wer    = in_wer;
      assign d_wb_sel = in_wb_sel;
      assign d_rd     = in_rd;
    end else begin : g_body
      assign d_valid  = st_valid[k-1];
      assign d_wer    = st_wer[k-1];
      assign d_wb_sel = st_wb_sel[k-1];
      assign d_rd     = st_rd[k-1];
    end

    wb_pipe_stage #(
      .WB_W (WB_W),
      .RD_W (RD_W)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .hold     (stall),
      .clear    (flush),
      .d_valid  (d_valid),
      .d_wer    (d_wer),
      .d_wb_sel (d_wb_sel),
      .d_rd     (d_rd),
      .q_valid  (st_valid[k]),
      .q_wer    (st_wer[k]),
      .q_wb_sel (st_wb_sel[k]),
      .q_rd     (st_rd[k])
    );
  end

  assign out_valid   = st_valid[STAGES-1];
  assign werf_contrl = out_valid & st_wer[STAGES-1];
  assign wb_contrl   = out_valid ? st_wb_sel[STAGES-1] : '0;
  assign wb_rd       = out_valid ? st_rd[STAGES-1] : '0;

  always_comb begin
    hazard_rs1 = 1'b0;
    hazard_rs2 = 1'b0;
    occupancy  = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + OCC_W'(st_valid[k]);
      if (k < HC) begin
        if (st_valid[k] && st_wer[k] && (st_rd[k] == rs1) && (rs1 != '0)) hazard_rs1 = 1'b1;
        if (st_valid[k] && st_wer[k] && (st_rd[k] == rs2) && (rs2 != '0)) hazard_rs2 = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_ctrl_pipe.sv
// Bench for wb_ctrl_pipe: directed vector table, hand sequences and random stimulus vs a queue-level model.
`timescale 1ns/1ps
module tb_wb_ctrl_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid, in_wer, stall, flush;
  logic [2:0] in_sel;
  logic [4:0] in_rd, rs1, rs2;

  int checks = 0;
  int errors = 0;

  // ---------------- DUTs: STAGES=3 / 1 / 8 ----------------
  logic       w0_werf, w0_ov, w0_h1, w0_h2;
  logic [1:0] w0_wb, w0_occ;
  logic [4:0] w0_rd;
  logic       w1_werf, w1_ov, w1_h1, w1_h2;
  logic [2:0] w1_wb;
  logic [0:0] w1_occ;
  logic [4:0] w1_rd;
  logic       w2_werf, w2_ov, w2_h1, w2_h2;
  logic [2:0] w2_wb;
  logic [3:0] w2_occ;
  logic [4:0] w2_rd;

  wb_ctrl_pipe #(.STAGES(3), .WB_W(2), .RD_W(5), .WB_BYPASS(1)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_wer(in_wer), .in_wb_sel(in_sel[1:0]),
    .in_rd(in_rd), .stall(stall), .flush(flush), .rs1(rs1), .rs2(rs2),
    .werf_contrl(w0_werf), .wb_contrl(w0_wb), .wb_rd(w0_rd), .out_valid(w0_ov),
    .hazard_rs1(w0_h1), .hazard_rs2(w0_h2), .occupancy(w0_occ));

  wb_ctrl_pipe #(.STAGES(1), .WB_W(3), .RD_W(5), .WB_BYPASS(0)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_wer(in_wer), .in_wb_sel(in_sel),
    .in_rd(in_rd), .stall(stall), .flush(flush), .rs1(rs1), .rs2(rs2),
    .werf_contrl(w1_werf), .wb_contrl(w1_wb), .wb_rd(w1_rd), .out_valid(w1_ov),
    .hazard_rs1(w1_h1), .hazard_rs2(w1_h2), .occupancy(w1_occ));

  wb_ctrl_pipe #(.STAGES(8), .WB_W(3), .RD_W(5), .WB_BYPASS(1)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_wer(in_wer), .in_wb_sel(in_sel),
    .in_rd(in_rd), .stall(stall), .flush(flush), .rs1(rs1), .rs2(rs2),
    .werf_contrl(w2_werf), .wb_contrl(w2_wb), .wb_rd(w2_rd), .out_valid(w2_ov),
    .hazard_rs1(w2_h1), .hazard_rs2(w2_h2), .occupancy(w2_occ));

  logic       d_werf [3];
  logic [2:0] d_wb   [3];
  logic [4:0] d_rd   [3];
  logic       d_ov   [3];
  logic       d_h1   [3];
  logic       d_h2   [3];
  logic [3:0] d_occ  [3];
  assign d_werf[0] = w0_werf; assign d_wb[0] = {1'b0, w0_wb}; assign d_rd[0] = w0_rd;
  assign d_ov[0]   = w0_ov;   assign d_h1[0] = w0_h1; assign d_h2[0] = w0_h2; assign d_occ[0] = {2'b00, w0_occ};
  assign d_werf[1] = w1_werf; assign d_wb[1] = w1_wb; assign d_rd[1] = w1_rd;
  assign d_ov[1]   = w1_ov;   assign d_h1[1] = w1_h1; assign d_h2[1] = w1_h2; assign d_occ[1] = {3'b000, w1_occ};
  assign d_werf[2] = w2_werf; assign d_wb[2] = w2_wb; assign d_rd[2] = w2_rd;
  assign d_ov[2]   = w2_ov;   assign d_h1[2] = w2_h1; assign d_h2[2] = w2_h2; assign d_occ[2] = w2_occ;

  // ---------------- reference model: an ordered list of in-flight slots per DUT ----------------
  int   dep [3] = '{3, 1, 8};
  bit   byp [3] = '{1'b1, 1'b0, 1'b1};
  int   smask [3] = '{3, 7, 7};
  logic       m_v [3][8];
  logic       m_w [3][8];
  logic [2:0] m_s [3][8];
  logic [4:0] m_r [3][8];

  task automatic model_reset();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 8; k++) begin
        m_v[i][k] = 1'b0; m_w[i][k] = 1'b0; m_s[i][k] = '0; m_r[i][k] = '0;
      end
  endtask

  // Applied once per rising edge with the inputs that were present at that edge.
  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      if (flush) begin
        for (int k = 0; k < 8; k++) begin
          m_v[i][k] = 1'b0; m_w[i][k] = 1'b0; m_s[i][k] = '0; m_r[i][k] = '0;
        end
      end else if (!stall) begin
        for (int k = dep[i] - 1; k > 0; k--) begin
          m_v[i][k] = m_v[i][k-1]; m_w[i][k] = m_w[i][k-1];
          m_s[i][k] = m_s[i][k-1]; m_r[i][k] = m_r[i][k-1];
        end
        m_v[i][0] = in_valid;
        m_w[i][0] = in_valid & in_wer;
        m_s[i][0] = in_valid ? (in_sel & 3'(smask[i])) : 3'd0;
        m_r[i][0] = in_valid ? in_rd : 5'd0;
      end
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    int   d, hc, occ;
    logic ov, h1, h2;
    for (int i = 0; i < 3; i++) begin
      d = dep[i];
      hc = byp[i] ? d - 1 : d;
      occ = 0; h1 = 1'b0; h2 = 1'b0;
      for (int k = 0; k < d; k++) begin
        occ += int'(m_v[i][k]);
        if (k < hc && m_v[i][k] && m_w[i][k] && m_r[i][k] == rs1 && rs1 != 0) h1 = 1'b1;
        if (k < hc && m_v[i][k] && m_w[i][k] && m_r[i][k] == rs2 && rs2 != 0) h2 = 1'b1;
      end
      ov = m_v[i][d-1];
      chk($sformatf("%s d%0d out_valid", tag, i), 32'(d_ov[i]), 32'(ov));
      chk($sformatf("%s d%0d werf", tag, i), 32'(d_werf[i]), 32'(ov & m_w[i][d-1]));
      chk($sformatf("%s d%0d wb", tag, i), 32'(d_wb[i]), ov ? 32'(m_s[i][d-1]) : 32'd0);
      chk($sformatf("%s d%0d wb_rd", tag, i), 32'(d_rd[i]), ov ? 32'(m_r[i][d-1]) : 32'd0);
      chk($sformatf("%s d%0d hz1", tag, i), 32'(d_h1[i]), 32'(h1));
      chk($sformatf("%s d%0d hz2", tag, i), 32'(d_h2[i]), 32'(h2));
      chk($sformatf("%s d%0d occ", tag, i), 32'(d_occ[i]), 32'(occ));
    end
  endtask

  // ---------------- driver tasks (called on the falling edge) ----------------
  task automatic apply(input logic v, input logic w, input logic [2:0] s, input logic [4:0] r,
                       input logic st, input logic fl, input logic [4:0] a, input logic [4:0] b,
                       input string tag);
    in_valid = v; in_wer = w; in_sel = s; in_rd = r;
    stall = st; flush = fl; rs1 = a; rs2 = b;
    #1;
    compare_model(tag);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // ---------------- directed vector table (STAGES=3 instance) ----------------
  typedef struct {
    logic v, w; logic [2:0] s; logic [4:0] r; logic st, fl; logic [4:0] a, b;
    logic e_werf; logic [1:0] e_wb; logic [4:0] e_rd; logic e_ov, e_h1, e_h2; logic [1:0] e_occ;
  } vec_t;

  function automatic vec_t mk(int v, int w, int s, int r, int st, int fl, int a, int b,
                              int ew, int ewb, int erd, int eov, int eh1, int eh2, int eocc);
    vec_t m;
    m.v = 1'(v); m.w = 1'(w); m.s = 3'(s); m.r = 5'(r); m.st = 1'(st); m.fl = 1'(fl);
    m.a = 5'(a); m.b = 5'(b); m.e_werf = 1'(ew); m.e_wb = 2'(ewb); m.e_rd = 5'(erd);
    m.e_ov = 1'(eov); m.e_h1 = 1'(eh1); m.e_h2 = 1'(eh2); m.e_occ = 2'(eocc);
    return m;
  endfunction

  vec_t tbl [9];

  initial begin
    //            v w s r  st fl rs1 rs2 | werf wb rd ov h1 h2 occ
    tbl[0] = mk(1,1,1,5, 0,0, 0,0,   0,0,0,0,0,0,0);
    tbl[1] = mk(1,1,2,7, 0,0, 5,0,   0,0,0,0,1,0,1);
    tbl[2] = mk(0,1,3,9, 0,0, 7,5,   0,0,0,0,1,1,2);
    tbl[3] = mk(1,0,3,4, 0,0, 5,7,   1,1,5,1,0,1,2);
    tbl[4] = mk(1,1,1,6, 1,0, 4,0,   1,2,7,1,0,0,2);
    tbl[5] = mk(1,1,0,0, 0,0, 0,0,   1,2,7,1,0,0,2);
    tbl[6] = mk(1,1,1,3, 1,1, 0,4,   0,0,0,0,0,0,2);
    tbl[7] = mk(0,0,0,0, 0,0, 3,3,   0,0,0,0,0,0,0);
    tbl[8] = mk(0,0,0,0, 0,0, 0,0,   0,0,0,0,0,0,0);

    // reset state
    reset = 1'b0;
    in_valid = 0; in_wer = 0; in_sel = 0; in_rd = 0; stall = 0; flush = 0; rs1 = 0; rs2 = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    apply(0, 0, 0, 0, 0, 0, 0, 0, "reset");
    reset = 1'b1;

    // table-driven vectors
    for (int t = 0; t < 9; t++) begin
      in_valid = tbl[t].v; in_wer = tbl[t].w; in_sel = tbl[t].s; in_rd = tbl[t].r;
      stall = tbl[t].st; flush = tbl[t].fl; rs1 = tbl[t].a; rs2 = tbl[t].b;
      #1;
      chk($sformatf("tbl%0d werf", t), 32'(w0_werf), 32'(tbl[t].e_werf));
      chk($sformatf("tbl%0d wb", t), 32'(w0_wb), 32'(tbl[t].e_wb));
      chk($sformatf("tbl%0d wb_rd", t), 32'(w0_rd), 32'(tbl[t].e_rd));
      chk($sformatf("tbl%0d out_valid", t), 32'(w0_ov), 32'(tbl[t].e_ov));
      chk($sformatf("tbl%0d hz1", t), 32'(w0_h1), 32'(tbl[t].e_h1));
      chk($sformatf("tbl%0d hz2", t), 32'(w0_h2), 32'(tbl[t].e_h2));
      chk($sformatf("tbl%0d occ", t), 32'(w0_occ), 32'(tbl[t].e_occ));
      compare_model($sformatf("tbl%0d", t));
      advance();
    end

    // stall two cycles with three entries in flight: order kept, delay of two
    for (int e = 1; e <= 3; e++) begin
      apply(1, 1, 3'(e), 5'(e), 0, 0, 0, 0, "fill");
      advance();
    end
    for (int c = 0; c < 2; c++) begin
      apply(1, 1, 0, 9, 1, 0, 0, 0, "stall");
      chk("stall rd frozen", 32'(w0_rd), 32'd1);
      chk("stall occ held", 32'(w0_occ), 32'd3);
      advance();
    end
    for (int e = 1; e <= 3; e++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0, "drain");
      chk($sformatf("drain order %0d", e), 32'(w0_rd), 32'(e));
      advance();
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, "drained");
    chk("drained out_valid", 32'(w0_ov), 32'd0);
    advance();

    // asynchronous reset mid-cycle with entries in flight
    for (int e = 0; e < 3; e++) begin
      apply(1, 1, 2, 5'(10 + e), 0, 0, 0, 0, "prefill");
      advance();
    end
    apply(1, 1, 1, 20, 0, 0, 10, 11, "pre_areset");
    @(posedge clk);
    model_update();
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("areset werf", 32'(w0_werf), 32'd0);
    chk("areset out_valid", 32'(w2_ov | w1_ov | w0_ov), 32'd0);
    chk("areset occ", 32'(w0_occ), 32'd0);
    chk("areset occ8", 32'(w2_occ), 32'd0);
    compare_model("areset");
    @(negedge clk);
    reset = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 10, 11, "post_areset");
    advance();

    // continuous input: occupancy saturates at STAGES
    for (int c = 0; c < 10; c++) begin
      apply(1, 1, 3'($urandom_range(0, 7)), 5'($urandom_range(1, 31)), 0, 0, 0, 0, "sat");
      advance();
    end
    apply(1, 1, 1, 1, 0, 0, 0, 0, "sat_end");
    chk("sat occ3", 32'(w0_occ), 32'd3);
    chk("sat occ1", 32'(w1_occ), 32'd1);
    chk("sat occ8", 32'(w2_occ), 32'd8);
    advance();

    // randomized stimulus against the model
    for (int c = 0; c < 400; c++) begin
      apply(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), "rand");
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
